// File: rtl/tswitch_pkg.sv
// Shared types and constants for the transmit-switch issue path.
//   issue_arb_state_t         : issue_arbiter FSM encoding
//   ISSUE_ARB_TIMEOUT_DEFAULT : default watchdog limit, in WAIT cycles
package tswitch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    ABORT = 2'd3
  } issue_arb_state_t;

  localparam int ISSUE_ARB_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req : request vector
//   ptr : index with the highest priority (must be < N)
//   gnt : one-hot grant, zero when no request is set
//   idx : index of the granted bit
//   any : at least one request is set
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  // Scan from ptr upward and wrap; the first set bit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/issue_arbiter.sv
// Shares one parallel_issuer between NUM_REQ requesters, one grant at a time.
//   clk, rst        : clock, async active-high reset
//   req_valid/mask  : per-requester request and target port mask
//   req_ready       : one-hot accept (combinational, IDLE only)
//   req_done        : 1-cycle pulse to owner on completion
//   req_timeout     : 1-cycle pulse to owner when the watchdog aborts
//   iss_start/clear : issuer control pulses
//   iss_target_mask : latched mask of the current grant
//   iss_issuing     : issuer busy
//   busy            : FSM not idle
module issue_arbiter
  import tswitch_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = ISSUE_ARB_TIMEOUT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*NUM_PORTS-1:0] req_mask,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           req_done,
  output logic [NUM_REQ-1:0]           req_timeout,
  output logic                         iss_start,
  output logic                         iss_clear,
  output logic [NUM_PORTS-1:0]         iss_target_mask,
  input  logic                         iss_issuing,
  output logic                         busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  issue_arb_state_t     state;
  logic [IW-1:0]        ptr, owner;
  logic [TW-1:0]        timer;
  logic [NUM_PORTS-1:0] mask_q;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 grant;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // No grant while the issuer is still busy (it would ignore start), and
  // none while reset is held so every output reads 0 during reset.
  assign grant           = (state == IDLE) && pick_any && !iss_issuing && !rst;
  assign req_ready       = grant ? pick_gnt : '0;
  assign iss_start       = (state == START);
  assign iss_clear       = (state == ABORT);
  assign busy            = (state != IDLE);
  assign iss_target_mask = mask_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      timer       <= '0;
      mask_q      <= '0;
      req_done    <= '0;
      req_timeout <= '0;
    end else begin
      req_done    <= '0;
      req_timeout <= '0;
      case (state)
        IDLE: if (grant) begin
          owner  <= pick_idx;
          mask_q <= req_mask[pick_idx*NUM_PORTS +: NUM_PORTS];
          ptr    <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state  <= START;
        end
        START: begin
          timer <= '0;
          state <= WAIT;
        end
        // issuing falling is the completion signal; it is checked before
        // the watchdog so a completion on the expiry cycle still counts.
        WAIT: begin
          if (!iss_issuing) begin
            req_done[owner] <= 1'b1;
            state           <= IDLE;
          end else if (TIMEOUT_CYCLES != 0 && timer == TLAST) begin
            state <= ABORT;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        ABORT: begin
          req_timeout[owner] <= 1'b1;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_arbiter.sv
module tb_issue_arbiter;

  localparam int NR = 2;
  localparam int NP = 4;
  localparam int TC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR*NP-1:0] req_mask = '0;
  logic [NR-1:0] req_ready, req_done, req_timeout;
  logic          iss_start, iss_clear, busy;
  logic [NP-1:0] iss_target_mask;
  logic          iss_issuing;

  logic [NP-1:0] port_rdy = '1;
  logic [NP-1:0] pend;

  int total  = 0;
  int passed = 0;

  issue_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP), .TIMEOUT_CYCLES(TC)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_mask        (req_mask),
    .req_ready       (req_ready),
    .req_done        (req_done),
    .req_timeout     (req_timeout),
    .iss_start       (iss_start),
    .iss_clear       (iss_clear),
    .iss_target_mask (iss_target_mask),
    .iss_issuing     (iss_issuing),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Issuer model: busy from the edge after start until the edge after the
  // last targeted port accepts; a zero mask finishes one cycle after start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_issuing <= 1'b0;
      pend        <= '0;
    end else if (iss_clear) begin
      iss_issuing <= 1'b0;
      pend        <= '0;
    end else if (!iss_issuing && iss_start) begin
      iss_issuing <= 1'b1;
      pend        <= iss_target_mask;
    end else if (iss_issuing) begin
      pend <= pend & ~port_rdy;
      if ((pend & ~port_rdy) == '0) iss_issuing <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [NR-1:0] own [3];
    own[0] = 2'b01; own[1] = 2'b10; own[2] = 2'b01;

    // Reset: all outputs 0 even with requests pending.
    req_valid = 2'b11;
    step(); #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_done", req_done, 0);
    chk("rst_tmo", req_timeout, 0);
    chk("rst_start", iss_start, 0);
    chk("rst_clear", iss_clear, 0);
    chk("rst_mask", iss_target_mask, 0);
    chk("rst_busy", busy, 0);
    req_valid = '0;
    step(); rst = 1'b0;

    // Both requesters valid: owners 0,1,0, back-to-back at done cycle.
    step();
    req_mask = {4'b0110, 4'b0001}; req_valid = 2'b11; #1;
    for (int g = 0; g < 3; g++) begin
      chk("rr_ready", req_ready, own[g]);
      step(); #1;
      chk("rr_start", iss_start, 1);
      chk("rr_mask", iss_target_mask, (own[g] == 2'b01) ? 4'b0001 : 4'b0110);
      step(); #1;
      chk("rr_done_early", req_done, 0);
      step(); #1;
      chk("rr_done_early", req_done, 0);
      step(); #1;
      chk("rr_done", req_done, own[g]);
      if (g == 2) begin req_valid = '0; #1; end
    end

    // Single request, mask 1010: minimum latency.
    step();
    req_mask = {4'b0000, 4'b1010}; req_valid = 2'b01; #1;
    chk("t1_ready", req_ready, 2'b01);
    chk("t1_busy0", busy, 0);
    step(); req_valid = '0; #1;
    chk("t1_start", iss_start, 1);
    chk("t1_mask", iss_target_mask, 4'b1010);
    chk("t1_ready_off", req_ready, 0);
    step(); #1;
    chk("t1_start_once", iss_start, 0);
    chk("t1_busy", busy, 1);
    step(); step(); #1;
    chk("t1_done", req_done, 2'b01);
    chk("t1_busy_lo", busy, 0);
    chk("t1_tmo", req_timeout, 0);

    // Timeout: port 2 stalls, requester 1 (pointer is 1).
    step();
    port_rdy = 4'b1011; req_mask = {4'b0100, 4'b0011}; req_valid = 2'b10; #1;
    chk("to_ready", req_ready, 2'b10);
    step(); req_valid = '0; #1;
    chk("to_start", iss_start, 1);
    for (int k = 2; k <= 9; k++) begin
      step(); #1;
      chk("to_wait_clear", iss_clear, 0);
      chk("to_wait_busy", busy, 1);
    end
    step(); #1;
    chk("to_clear", iss_clear, 1);
    chk("to_tmo_early", req_timeout, 0);
    step(); #1;
    chk("to_tmo", req_timeout, 2'b10);
    chk("to_nodone", req_done, 0);
    chk("to_clear_once", iss_clear, 0);
    chk("to_busy_lo", busy, 0);
    // Next grant proceeds normally.
    port_rdy = '1; req_valid = 2'b01; #1;
    chk("to_next_ready", req_ready, 2'b01);
    step(); req_valid = '0; #1;
    chk("to_next_mask", iss_target_mask, 4'b0011);
    step(); step(); step(); #1;
    chk("to_next_done", req_done, 2'b01);

    // Zero mask from requester 1.
    step();
    req_mask = {4'b0000, 4'b0000}; req_valid = 2'b10; #1;
    chk("zm_ready", req_ready, 2'b10);
    step(); req_valid = '0; #1;
    chk("zm_start", iss_start, 1);
    chk("zm_mask", iss_target_mask, 0);
    step(); step(); step(); #1;
    chk("zm_done", req_done, 2'b10);
    chk("zm_tmo", req_timeout, 0);
    step(); #1;
    chk("zm_tmo_after", req_timeout, 0);

    // Completion on the same WAIT cycle the timer hits its limit.
    port_rdy = 4'b1011; req_mask = {4'b0000, 4'b0100}; req_valid = 2'b01; #1;
    chk("sc_ready", req_ready, 2'b01);
    step(); req_valid = '0;
    for (int k = 2; k <= 8; k++) step();
    port_rdy = '1;
    step(); #1;
    chk("sc_busy", busy, 1);
    chk("sc_done_early", req_done, 0);
    step(); #1;
    chk("sc_done", req_done, 2'b01);
    chk("sc_clear", iss_clear, 0);
    chk("sc_busy_lo", busy, 0);
    step(); #1;
    chk("sc_tmo", req_timeout, 0);

    // Reset during WAIT, then fresh start from pointer 0.
    port_rdy = 4'b1011; req_mask = {4'b0100, 4'b0001}; req_valid = 2'b10; #1;
    chk("rw_ready", req_ready, 2'b10);
    step(); step(); step(); #1;
    chk("rw_busy", busy, 1);
    rst = 1'b1; req_valid = 2'b11; #1;
    chk("rw_ready0", req_ready, 0);
    chk("rw_busy0", busy, 0);
    chk("rw_mask0", iss_target_mask, 0);
    chk("rw_start0", iss_start | iss_clear, 0);
    chk("rw_pulse0", {req_done, req_timeout}, 0);
    step(); rst = 1'b0; port_rdy = '1; #1;
    chk("rw_first", req_ready, 2'b01);
    step(); req_valid = '0; #1;
    chk("rw_mask", iss_target_mask, 4'b0001);
    for (int k = 2; k <= 3; k++) begin
      step(); #1;
      chk("rw_stale", {req_done, req_timeout}, 0);
    end
    step(); #1;
    chk("rw_done", req_done, 2'b01);
    chk("rw_tmo", req_timeout, 0);
    for (int k = 0; k < 12; k++) begin
      step(); #1;
      chk("rw_quiet", {req_done, req_timeout, busy}, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/issue_arbiter.md
# issue_arbiter

Shares one `parallel_issuer` instance between `NUM_REQ` requesters, such as the read requester and the multicast engine. Each grant runs to completion before the next one begins. The block does four things: picks a winner round-robin, latches its port mask, pulses the issuer's `start`, and watches `issuing` to detect completion. A watchdog aborts with `clear` if a grant stalls, and the owner receives either a `done` pulse or a `timeout` pulse.

## Interface
- `NUM_REQ`, 2: number of requesters (≥2).
- `NUM_PORTS`, 4: width of the issuer port mask.
- `TIMEOUT_CYCLES`, 1024: maximum WAIT cycles before abort; 0 disables the watchdog.

- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i wants to issue.
- `req_mask`  in  NUM_REQ*NUM_PORTS  target mask of requester i in bits [i*NUM_PORTS +: NUM_PORTS]; must be stable while `req_valid[i]` is high.
- `req_ready`  out  NUM_REQ  one-hot accept, combinational, high only in IDLE.
- `req_done`  out  NUM_REQ  registered 1-cycle pulse to the owner when all targeted ports have accepted.
- `req_timeout`  out  NUM_REQ  registered 1-cycle pulse to the owner when its grant is aborted.
- `iss_start`  out  1  start pulse to the issuer.
- `iss_clear`  out  1  clear pulse to the issuer.
- `iss_target_mask`  out  NUM_PORTS  latched mask; held through START and WAIT.
- `iss_issuing`  in  1  issuer busy.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Issuer contract:
  - `start` is ignored while the issuer is busy.
  - `issuing` rises on the edge after `start`.
  - `issuing` falls on the edge after the last port accepts.
  - A zero mask completes one cycle after `start`.
  - `all_issued` is not used, because it can be missed.
- States: IDLE, START, WAIT, ABORT. Reset state is IDLE.
- IDLE:
  - Grant only if some `req_valid` is high and `iss_issuing` = 0.
  - Winner is the first valid index at or after the RR pointer, wrapping around.
  - Drive `req_ready[w]` = 1, latch the mask and owner w, set pointer = (w+1) mod NUM_REQ, go to START.
  - If `iss_issuing` = 1 in IDLE, `req_ready` stays 0.
- START: `iss_start` = 1 for exactly one cycle, timer cleared to 0, go to WAIT.
- WAIT:
  - If `iss_issuing` = 0: go to IDLE and register `req_done[owner]`.
  - Else if `TIMEOUT_CYCLES` ≠ 0 and timer = `TIMEOUT_CYCLES`-1: go to ABORT.
  - Else: timer++.
  - Completion wins over timeout in the same cycle.
- ABORT: `iss_clear` = 1 for one cycle, register `req_timeout[owner]`, go to IDLE.
- Timer width is `$clog2(TIMEOUT_CYCLES+1)` (minimum 1) and saturates; it never wraps.
- A zero mask goes through the normal path and completes with `req_done`, not an error.
- Reset mid-grant:
  - State returns to IDLE and the pointer to 0.
  - All outputs go to 0.
  - No done or timeout pulse is emitted for the lost grant.
  - The issuer shares the same reset.

## Timing
- Reset values: `req_ready`, `req_done`, `req_timeout`, `iss_start`, `iss_clear`, `iss_target_mask`, `busy` are all 0.
- Accept at cycle T:
  - `iss_start` at T+1.
  - WAIT from T+2.
  - If all targeted ports are ready at T+2, `req_done` is high at T+4. This is the minimum latency.
- Back-to-back: the next accept may occur in the same cycle as the previous `req_done` (T+4). Throughput is one grant per 4 cycles at best.
- A timeout fires `TIMEOUT_CYCLES` cycles after WAIT entry: ABORT in the next cycle, `req_timeout` high the cycle after ABORT.
- `req_done` and `req_timeout` are mutually exclusive per grant. Neither is ever asserted to a non-owner.

## Structure
- `tswitch_pkg` holds:
  - `issue_arb_state_t` enum (IDLE, START, WAIT, ABORT).
  - `ISSUE_ARB_TIMEOUT_DEFAULT` constant.
- Sub-module `rr_pick`: combinational round-robin selector; inputs are the request vector and pointer, outputs are a one-hot grant and an index. It is reused by later schedulers.
- The top level instantiates no issuer. It connects beside `parallel_issuer` in the wrapper.

## Test plan
- Single request, `req_mask`=4'b1010, issuer model with ports always ready → `req_ready` at T, `iss_start` at T+1 with `iss_target_mask`=4'b1010, `req_done[0]` at T+4, `busy` low at T+4.
- Both requesters valid continuously, 3 grants → owners in order 0, 1, 0; one `req_done` per grant.
- Port 2 held not-ready, `TIMEOUT_CYCLES`=8 → ABORT after 8 WAIT cycles, `iss_clear` for one cycle, `req_timeout[owner]` pulse, no `req_done`, then the next grant proceeds.
- Zero mask → `iss_start` issued, `req_done` at T+4, `req_timeout` stays 0.
- Completion and timer expiry on the same WAIT cycle → `req_done` only.
- Assert `rst` during WAIT → all outputs 0 immediately. After release, IDLE with pointer 0, the first grant goes to requester 0, and no stale pulses appear.
